// File: rtl/jtag_master.sv
// jtag_master -- command-driven JTAG scan master.
//
// Accepts IR scan, DR scan and TAP-reset commands, walks the target TAP from
// Run-Test/Idle through the matching preamble, shift and postamble, and
// returns the captured TDO bits as a response. After reset the block first
// drives a Test-Logic-Reset sequence so that its idea of the target TAP
// (Run-Test/Idle whenever the FSM sits in IDLE) is valid.
//
// Parameters:
//   DATA_W  : maximum scan length in bits, width of cmd_data / rsp_data
//   CLK_DIV : TCK half-period in clk cycles (>= 1)
//   LEN_W   : width of cmd_len
//
// Ports:
//   clk, reset_n             : system clock, synchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake
//   cmd_type                 : 00 IR scan, 01 DR scan, 1x TAP reset
//   cmd_len, cmd_data        : bits to shift, TDI bits (LSB first)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_data                 : captured TDO bits (LSB first)
//   busy                     : sequence in progress
//   tck_o, tms_o, tdi_o      : JTAG outputs to the target
//   trst_n_o                 : target reset (only with JTAG_MASTER_TRST_EN)
//   tdo_i                    : JTAG data from the target
//
// Handshakes: a transfer happens on a clk edge where valid and ready are both
// high. cmd_ready is high only in IDLE; rsp_valid stays high with stable
// rsp_data until rsp_ready is seen.
//
// Optional feature macro: JTAG_MASTER_TRST_EN adds trst_n_o.

module jtag_master #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_type,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
`ifdef JTAG_MASTER_TRST_EN
    output logic              trst_n_o,
`endif
    input  logic              tdo_i
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        INIT_TLR,
        IDLE,
        PRE,
        SHIFT,
        POST,
        RESP
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;       // clk cycles within the current TCK half
    logic [2:0]         seq_idx;   // position in TLR / preamble / postamble
    logic [IDX_W-1:0]   bit_idx;   // current shift bit
    logic [LEN_W-1:0]   len_q;
    logic [DATA_W-1:0]  data_q;
    logic               is_ir;
    logic               want_rsp;  // TLR issued by a command, not by reset
    logic [LEN_W-1:0]   len_clamp;
    logic               last_shift;
    logic               next_last_shift;
    logic [IDX_W-1:0]   next_idx;

    always_comb begin
        len_clamp = cmd_len;
        if (cmd_len == '0)
            len_clamp = LEN_W'(1);
        else if (cmd_len > LEN_W'(DATA_W))
            len_clamp = LEN_W'(DATA_W);
    end

    assign next_idx        = bit_idx + IDX_W'(1);
    assign last_shift      = (LEN_W'(bit_idx) + LEN_W'(1)) == len_q;
    assign next_last_shift = (LEN_W'(bit_idx) + LEN_W'(2)) == len_q;

    // All TCK sequencing lives here. The edge that ends a high phase is also
    // the edge that starts the next low phase, so TMS/TDI for the next
    // period are loaded there together with tck_o going low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= INIT_TLR;
            cnt       <= '0;
            seq_idx   <= '0;
            bit_idx   <= '0;
            len_q     <= LEN_W'(1);
            data_q    <= '0;
            is_ir     <= 1'b0;
            want_rsp  <= 1'b0;
            tck_o     <= 1'b0;
            tms_o     <= 1'b1;
            tdi_o     <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            busy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        seq_idx   <= '0;
                        bit_idx   <= '0;
                        len_q     <= len_clamp;
                        data_q    <= cmd_data;
                        rsp_data  <= '0;
                        tck_o     <= 1'b0;
                        tdi_o     <= 1'b0;
                        tms_o     <= 1'b1;   // first TMS of every sequence is 1
                        is_ir     <= ~cmd_type[0];
                        if (cmd_type[1]) begin
                            state    <= INIT_TLR;
                            want_rsp <= 1'b1;
                        end else begin
                            state    <= PRE;
                        end
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    if (cnt != HALF_LAST) begin
                        cnt <= cnt + CNT_W'(1);
                    end else begin
                        cnt <= '0;
                        if (!tck_o) begin
                            tck_o <= 1'b1;
                            if (state == SHIFT)
                                rsp_data[bit_idx] <= tdo_i;
                        end else begin
                            tck_o <= 1'b0;
                            case (state)
                                INIT_TLR: begin
                                    if (seq_idx == 3'd5) begin
                                        tms_o    <= 1'b0;
                                        busy     <= 1'b0;
                                        want_rsp <= 1'b0;
                                        if (want_rsp) begin
                                            state     <= RESP;
                                            rsp_valid <= 1'b1;
                                        end else begin
                                            state     <= IDLE;
                                            cmd_ready <= 1'b1;
                                        end
                                    end else begin
                                        seq_idx <= seq_idx + 3'd1;
                                        // TMS 1,1,1,1,1 then a final 0
                                        tms_o   <= (seq_idx != 3'd4);
                                    end
                                end

                                PRE: begin
                                    if ((is_ir && seq_idx == 3'd3) ||
                                        (!is_ir && seq_idx == 3'd2)) begin
                                        state   <= SHIFT;
                                        bit_idx <= '0;
                                        tms_o   <= (len_q == LEN_W'(1));
                                        tdi_o   <= data_q[0];
                                    end else begin
                                        seq_idx <= seq_idx + 3'd1;
                                        // IR: 1,1,0,0   DR: 1,0,0
                                        tms_o   <= is_ir && (seq_idx == 3'd0);
                                    end
                                end

                                SHIFT: begin
                                    if (last_shift) begin
                                        state   <= POST;
                                        seq_idx <= '0;
                                        tms_o   <= 1'b1;
                                        tdi_o   <= 1'b0;
                                    end else begin
                                        bit_idx <= next_idx;
                                        tms_o   <= next_last_shift;
                                        tdi_o   <= data_q[next_idx];
                                    end
                                end

                                POST: begin
                                    if (seq_idx == 3'd0) begin
                                        seq_idx <= 3'd1;
                                        tms_o   <= 1'b0;
                                    end else begin
                                        state     <= RESP;
                                        tms_o     <= 1'b0;
                                        busy      <= 1'b0;
                                        rsp_valid <= 1'b1;
                                    end
                                end

                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

`ifdef JTAG_MASTER_TRST_EN
    // Low during reset and for the first TCK period of every TLR sequence.
    always_ff @(posedge clk) begin
        if (!reset_n)
            trst_n_o <= 1'b0;
        else if (state == IDLE && cmd_valid && cmd_type[1])
            trst_n_o <= 1'b0;
        else if (state == INIT_TLR && seq_idx == 3'd0 && tck_o && cnt == HALF_LAST)
            trst_n_o <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_jtag_master.sv
module tb_jtag_master;

    localparam int DATA_W  = 32;
    localparam int CLK_DIV = 2;
    localparam int LEN_W   = $clog2(DATA_W + 1);

    logic              clk;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;
    logic              tck_o;
    logic              tms_o;
    logic              tdi_o;
    logic              tdo_i = 1'b0;
`ifdef JTAG_MASTER_TRST_EN
    logic              trst_n_o;
`endif

    jtag_master #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_type  (cmd_type),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .tck_o     (tck_o),
        .tms_o     (tms_o),
        .tdi_o     (tdi_o),
`ifdef JTAG_MASTER_TRST_EN
        .trst_n_o  (trst_n_o),
`endif
        .tdo_i     (tdo_i)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters / scoreboard ----------------
    int checks = 0;
    int passes = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- target TAP model (bypass DR, 3-bit IR) ----------------
    typedef enum logic [3:0] {
        T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PAUDR, T_EX2DR, T_UPDDR,
        T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAUIR, T_EX2IR, T_UPDIR
    } tap_t;

    tap_t       tap_st = T_TLR;
    logic       bypass_r = 1'b0;
    logic [2:0] ir_sr = 3'b000;
    logic [2:0] ir_reg = 3'b000;
    bit         tms_log[$];
    bit         tdi_log[$];
    int         shift_cnt = 0;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            T_TLR:   return tms ? T_TLR   : T_RTI;
            T_RTI:   return tms ? T_SELDR : T_RTI;
            T_SELDR: return tms ? T_SELIR : T_CAPDR;
            T_CAPDR: return tms ? T_EX1DR : T_SHDR;
            T_SHDR:  return tms ? T_EX1DR : T_SHDR;
            T_EX1DR: return tms ? T_UPDDR : T_PAUDR;
            T_PAUDR: return tms ? T_EX2DR : T_PAUDR;
            T_EX2DR: return tms ? T_UPDDR : T_SHDR;
            T_UPDDR: return tms ? T_SELDR : T_RTI;
            T_SELIR: return tms ? T_TLR   : T_CAPIR;
            T_CAPIR: return tms ? T_EX1IR : T_SHIR;
            T_SHIR:  return tms ? T_EX1IR : T_SHIR;
            T_EX1IR: return tms ? T_UPDIR : T_PAUIR;
            T_PAUIR: return tms ? T_EX2IR : T_PAUIR;
            T_EX2IR: return tms ? T_UPDIR : T_SHIR;
            default: return tms ? T_SELDR : T_RTI;
        endcase
    endfunction

    always @(posedge tck_o) begin
        tms_log.push_back(tms_o);
        case (tap_st)
            T_CAPDR: bypass_r = 1'b0;
            T_CAPIR: ir_sr = 3'b001;
            T_SHDR: begin
                bypass_r = tdi_o;
                tdi_log.push_back(tdi_o);
                shift_cnt++;
            end
            T_SHIR: begin
                ir_sr = {tdi_o, ir_sr[2:1]};
                tdi_log.push_back(tdi_o);
                shift_cnt++;
            end
            T_UPDIR: ir_reg = ir_sr;
            default: ;
        endcase
        tap_st = tap_next(tap_st, tms_o);
    end

    always @(negedge tck_o) begin
        if (tap_st == T_SHDR)      tdo_i = bypass_r;
        else if (tap_st == T_SHIR) tdo_i = ir_sr[0];
        else                       tdo_i = 1'b0;
    end

    function automatic logic [63:0] pack_tms();
        logic [63:0] v = '0;
        foreach (tms_log[i]) v = {v[62:0], 1'(tms_log[i])};
        return v;
    endfunction

    function automatic logic [63:0] pack_tdi();
        logic [63:0] v = '0;
        foreach (tdi_log[i]) if (i < 64) v[i] = tdi_log[i];
        return v;
    endfunction

    // ---------------- waveform-rule monitor (values of the cycle just ended) ----------------
    int   timing_err = 0;
    int   edge_err = 0;
    int   rsp_cycles = 0;
    int   hi_run = 0;
    int   lo_run = 0;
    logic lo_valid = 1'b0;
    logic prev_rst = 1'b0;
    logic prev_tck = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_tms = 1'b0;
    logic prev_tdi = 1'b0;

    always @(posedge clk) begin
        if (rsp_valid === 1'b1) rsp_cycles++;
        if (!prev_rst) begin
            lo_run = 1; lo_valid = 1'b1; hi_run = 0;
        end else begin
            if ((tms_o !== prev_tms || tdi_o !== prev_tdi) &&
                !(tck_o === 1'b0 && (prev_tck || !prev_busy)))
                edge_err++;
            if (tck_o) begin
                if (!prev_tck && lo_valid && lo_run != CLK_DIV) timing_err++;
                hi_run++;
                lo_run = 0;
            end else if (prev_tck) begin
                if (hi_run != CLK_DIV) timing_err++;
                hi_run = 0; lo_run = 1; lo_valid = busy;
            end else if (!busy) begin
                lo_run = 0; lo_valid = 1'b0;
            end else if (!prev_busy) begin
                lo_run = 1; lo_valid = 1'b1;
            end else begin
                lo_run++;
            end
        end
        prev_rst  = reset_n;
        prev_tck  = tck_o;
        prev_busy = busy;
        prev_tms  = tms_o;
        prev_tdi  = tdi_o;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(cmd_ready), 64'd1);
    endtask

    task automatic wait_rsp_valid(input string tag, input int budget);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(rsp_valid), 64'd1);
    endtask

    task automatic send_cmd(input logic [1:0] t, input logic [LEN_W-1:0] l,
                            input logic [DATA_W-1:0] d);
        tms_log.delete();
        tdi_log.delete();
        shift_cnt = 0;
        cmd_type  = t;
        cmd_len   = l;
        cmd_data  = d;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("cmd_ready_after_accept", 64'(cmd_ready), 64'd0);
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    task automatic get_rsp(input string tag);
        wait_rsp_valid({tag, "_rsp_timeout"}, 600);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            check({tag, "_rsp_data"}, 64'(rsp_data), 64'(exp_q.pop_front()));
        end
        check({tag, "_busy_in_resp"}, 64'(busy), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, "_rsp_valid_drop"}, 64'(rsp_valid), 64'd0);
        check({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'd1);
        check({tag, "_tap_idle"}, 64'(tap_st), 64'(T_RTI));
    endtask

    // ---------------- directed sequence ----------------
    logic [DATA_W-1:0] d;
    logic [63:0]       mask;
    int                len;
    int                base;

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_type  = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_tck", 64'(tck_o), 64'd0);
        check("rst_tms", 64'(tms_o), 64'd1);
        check("rst_tdi", 64'(tdi_o), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd1);
`ifdef JTAG_MASTER_TRST_EN
        check("rst_trst", 64'(trst_n_o), 64'd0);
`endif

        // release: six-pulse TLR sequence, no response
        tms_log.delete();
        base = rsp_cycles;
        reset_n = 1'b1;
        wait_ready("init_ready", 200);
        check("init_tms_count", 64'(tms_log.size()), 64'd6);
        check("init_tms_seq", pack_tms(), 64'b111110);
        check("init_tap_idle", 64'(tap_st), 64'(T_RTI));
        check("init_no_rsp", 64'(rsp_cycles - base), 64'd0);
        check("init_busy", 64'(busy), 64'd0);
`ifdef JTAG_MASTER_TRST_EN
        check("init_trst_released", 64'(trst_n_o), 64'd1);
`endif

        // IR scan len 3, data 101, IR captures 001
        exp_q.push_back(DATA_W'(1));
        send_cmd(2'b00, LEN_W'(3), DATA_W'(3'b101));
        get_rsp("ir3");
        check("ir3_tms_count", 64'(tms_log.size()), 64'd9);
        check("ir3_tms_seq", pack_tms(), 64'b110000110);
        check("ir3_tdi_bits", pack_tdi(), 64'b101);
        check("ir3_ir_updated", 64'(ir_reg), 64'b101);

        // DR scan len 32 through bypass, response held off for 10 clk
        exp_q.push_back(32'h4B4A1E1E);
        send_cmd(2'b01, LEN_W'(32), 32'hA5A50F0F);
        wait_rsp_valid("dr32_valid", 600);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_data", 64'(rsp_data), 64'h4B4A1E1E);
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            check("hold_tck", 64'(tck_o), 64'd0);
        end
        get_rsp("dr32");
        check("dr32_shift_count", 64'(shift_cnt), 64'd32);
        check("dr32_tms_count", 64'(tms_log.size()), 64'd37);
        check("dr32_tdi_bits", pack_tdi(), 64'hA5A50F0F);

        // cmd_len 0 -> one shift bit
        exp_q.push_back(DATA_W'(0));
        send_cmd(2'b01, LEN_W'(0), 32'hFFFFFFFF);
        get_rsp("len0");
        check("len0_shift_count", 64'(shift_cnt), 64'd1);
        check("len0_tms_seq", pack_tms(), 64'b100110);

        // cmd_len 40 -> clamped to 32 shift bits
        exp_q.push_back(32'h2468ACF0);
        send_cmd(2'b01, LEN_W'(40), 32'h92345678);
        get_rsp("len40");
        check("len40_shift_count", 64'(shift_cnt), 64'd32);

        // random DR scans; bits at and above len must read 0
        for (int k = 0; k < 4; k++) begin
            len  = $urandom_range(1, DATA_W);
            d    = $urandom;
            mask = (64'd1 << len) - 64'd1;
            exp_q.push_back(DATA_W'({d, 1'b0} & mask[DATA_W:0]));
            send_cmd(2'b01, LEN_W'(len), d);
            get_rsp("rand_dr");
            check("rand_shift_count", 64'(shift_cnt), 64'(len));
            check("rand_tdi_bits", pack_tdi(), 64'(d) & mask);
        end

        // TAP reset commands (10 and reserved 11), response data 0
        for (int t = 2; t < 4; t++) begin
            exp_q.push_back(DATA_W'(0));
            send_cmd(2'(t), LEN_W'(5), 32'hFFFFFFFF);
`ifdef JTAG_MASTER_TRST_EN
            check("tlr_cmd_trst", 64'(trst_n_o), 64'd0);
`endif
            get_rsp("tlr_cmd");
            check("tlr_cmd_tms_seq", pack_tms(), 64'b111110);
            check("tlr_cmd_tms_count", 64'(tms_log.size()), 64'd6);
        end

        // reset mid-scan after 5 DR shift bits: abort, TLR, no response
        send_cmd(2'b01, LEN_W'(32), 32'h12345678);
        for (int n = 0; n < 400 && shift_cnt < 5; n++) @(negedge clk);
        check("midrst_reach_shift5", 64'(shift_cnt >= 5), 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_tck", 64'(tck_o), 64'd0);
        check("midrst_tms", 64'(tms_o), 64'd1);
        check("midrst_tdi", 64'(tdi_o), 64'd0);
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data", 64'(rsp_data), 64'd0);
        check("midrst_busy", 64'(busy), 64'd1);
        @(negedge clk);
        tms_log.delete();
        base = rsp_cycles;
        reset_n = 1'b1;
        wait_ready("midrst_ready", 200);
        check("midrst_tms_seq", pack_tms(), 64'b111110);
        check("midrst_tms_count", 64'(tms_log.size()), 64'd6);
        check("midrst_no_rsp", 64'(rsp_cycles - base), 64'd0);
        check("midrst_tap_idle", 64'(tap_st), 64'(T_RTI));

        // waveform rules over the whole run
        repeat (4) @(negedge clk);
        check("tck_phase_lengths", 64'(timing_err), 64'd0);
        check("tms_tdi_change_edges", 64'(edge_err), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
